// File: rtl/wb_stage_skid_reg_if.sv
// Handshake bundle between the MEM stage, the MEM->WB stage register and writeback.
// The stage register uses the slave modport; the surrounding pipeline uses master.
interface wb_stage_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NCH-1:0]        in_regwr;
    logic [NCH*DATA_W-1:0] in_data;
    logic [NCH*ADDR_W-1:0] in_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH-1:0]        out_regwr;
    logic [NCH*DATA_W-1:0] out_data;
    logic [NCH*ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_regwr, in_data, in_addr, out_ready,
        output in_ready, out_valid, out_regwr, out_data, out_addr
    );

    modport master (
        output in_valid, in_regwr, in_data, in_addr, out_ready,
        input  in_ready, out_valid, out_regwr, out_data, out_addr
    );
endinterface

// File: rtl/wb_stage_skid_reg.sv
// MEM->WB stage register carrying NCH register-write channels, with optional
// two-entry skid buffer and a combinational forwarding lookup for the hazard unit.
//
// state    | meaning
// ST_EMPTY | nothing held
// ST_ONE   | main entry valid, drives the output
// ST_FULL  | main and skid valid; skid is the younger entry (SKID=1 only)
module wb_stage_skid_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    wb_stage_skid_reg_if.slave bus,
    output logic [1:0]        occ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [NCH-1:0]        regwr;
        logic [NCH*DATA_W-1:0] data;
        logic [NCH*ADDR_W-1:0] addr;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_e;

    logic main_valid, skid_valid;
    logic in_ready, out_valid;
    logic accept, retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_FULL);

    // With the skid entry, ready depends only on registered state; without it,
    // ready looks through to out_ready so a held entry can be replaced in place.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = !skid_valid && !reset;
        end else begin : g_pass_ready
            assign in_ready = (!main_valid || bus.out_ready) && !reset;
        end
    endgenerate

    assign out_valid = main_valid && !reset;
    assign accept    = bus.in_valid && in_ready;
    assign retire    = out_valid && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_e.regwr = bus.in_regwr;
        in_e.data  = bus.in_data;
        in_e.addr  = bus.in_addr;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else if (retire && skid_valid) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
        end else if (retire && accept) begin
            main_d = in_e;
        end else if (retire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
        end else if (accept && main_valid) begin
            state_d = ST_FULL;
            skid_d  = in_e;
        end else if (accept) begin
            state_d = ST_ONE;
            main_d  = in_e;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_regwr = out_valid ? main_q.regwr : '0;
    assign bus.out_data  = reset ? '0 : main_q.data;
    assign bus.out_addr  = reset ? '0 : main_q.addr;
    assign occ           = reset ? 2'd0 : state_q;

    // Later matches overwrite earlier ones: scanning high->low channels, main
    // before skid, leaves the youngest entry's lowest channel as the winner.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (!reset && fwd_addr != '0) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (main_valid && main_q.regwr[k] &&
                    main_q.addr[k*ADDR_W +: ADDR_W] == fwd_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = main_q.data[k*DATA_W +: DATA_W];
                end
            end
            for (int k = NCH - 1; k >= 0; k--) begin
                if (skid_valid && skid_q.regwr[k] &&
                    skid_q.addr[k*ADDR_W +: ADDR_W] == fwd_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = skid_q.data[k*DATA_W +: DATA_W];
                end
            end
        end
    end
endmodule

// File: doc/wb_stage_skid_reg.md
Name: wb_stage_skid_reg

Overview:
- Parametrised MEM->WB pipeline stage register for the core.
- Successor to the single-channel stall/wash writeback register.
- Carries NCH independent register-write channels (e.g. GPR plus HI/LO) under a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput under backpressure; a combinational forwarding lookup serves the ID/EX hazard unit.

Parameters:
DATA_W, 32, width of each channel's write data
ADDR_W, 5, width of each channel's destination register address
NCH, 2, number of write channels per pipeline entry
SKID, 1, 1 = two-entry skid buffer; 0 = single entry with pass-through ready

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
flush  in  1  synchronous wash; discards all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_regwr  in  NCH  per-channel write enable
in_data  in  NCH*DATA_W  per-channel data; channel k at [k*DATA_W +: DATA_W]
in_addr  in  NCH*ADDR_W  per-channel destination address, same packing
out_valid  out  1  output entry valid
out_ready  in  1  writeback consumes the entry
out_regwr  out  NCH  per-channel write enable; forced 0 when out_valid=0
out_data  out  NCH*DATA_W  output data
out_addr  out  NCH*ADDR_W  output addresses
occ  out  2  entries held (0..2; max 1 when SKID=0)
fwd_addr  in  ADDR_W  forwarding query address
fwd_hit  out  1  a held valid entry writes fwd_addr
fwd_data  out  DATA_W  data for the matching write

Behaviour:
- Storage: main entry (drives out_*) and, if SKID=1, skid entry. Each entry holds valid, regwr[NCH], data, addr.
- Accept: in_valid && in_ready. Retire: out_valid && out_ready. Both may occur in one cycle.
- Reset: clears both entries (valid, regwr, data, addr = 0).
  - All outputs 0 and occ=0 while reset is high and on the following cycle.
  - in_ready=0 while reset is high.
  - Reset overrides flush and all handshakes. Reset mid-transfer discards everything; no partial entry survives.
- Flush: same clearing as reset, one clock edge.
  - An input accepted in the flush cycle is dropped.
  - in_ready follows its normal rule during flush.
  - Next cycle: occ=0, out_valid=0.
- SKID=1 states (occ):
  - EMPTY(0): accept -> ONE.
  - ONE(1):
    - accept, no retire -> FULL; new entry goes to skid.
    - accept + retire -> ONE; new entry loaded into main.
    - retire only -> EMPTY.
  - FULL(2):
    - in_ready=0.
    - retire -> ONE; skid moves to main, skid cleared.
    - no retire -> hold.
  - in_ready = !skid.valid && !reset. Registered-only dependence; no combinational path from out_ready.
  - Order strictly FIFO. Throughput 1 entry/cycle when out_ready is held 1. Latency in->out = 1 cycle.
- SKID=0:
  - in_ready = (!main.valid || out_ready) && !reset. Combinational path from out_ready is permitted.
  - States EMPTY/ONE only.
- An entry with all regwr=0 is still a valid entry (bubble carrying no write) and must be retired.
- Forwarding (combinational):
  - Candidates are valid entries whose channel has regwr=1 and addr==fwd_addr.
  - fwd_addr==0 never hits.
  - Priority: skid entry (younger) over main; within an entry, lowest channel index wins.
  - fwd_data = winning channel's data; 0 when fwd_hit=0.
- Held entries never change except by accept/retire/flush/reset. in_* values presented without a handshake have no effect.

Test Plan:
- Streaming, SKID=1: out_ready=1, 4 entries A0..A3 on consecutive cycles (ch0 addr=3+i, data=0x100+i) -> out_valid from cycle 1, one entry/cycle in order, in_ready stays 1, occ=1.
- Backpressure: out_ready=0, push 0xAA then 0xBB -> occ=2, in_ready=0, out_data ch0=0xAA; raise out_ready -> 0xAA then 0xBB retire in order; occ 2->1->0.
- Flush in FULL with simultaneous in_valid (data 0xCC) -> next cycle occ=0, out_valid=0, out_regwr=0, out_data=0; 0xCC never appears at the output.
- Forwarding: main ch1 writes r8=0x11, skid ch0 writes r8=0x22 -> fwd_addr=8 gives hit=1, data=0x22. fwd_addr=0 with an entry writing addr 0 -> hit=0, data=0.
- SKID=0: out_ready=0 with entry held -> in_ready=0; out_ready=1 in the same cycle as in_valid -> in_ready=1, entry replaced, occ stays 1.
- Reset mid-backpressure (occ=2) -> during reset in_ready=0, all outputs 0; after release occ=0, in_ready=1.
